// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: HH:MM:SS BCD time-of-day counter with a two-button set mode.
// Optional blink of the field being set: define CLOCK_TIME_CTRL_BLINK_EN.
//
// Ports:
//   rst          async active-low reset
//   in_clk       system clock, rising edge
//   tick         1 Hz enable pulse, one in_clk cycle wide
//   btn_mode     debounced mode button level (async)
//   btn_inc      debounced increment button level (async)
//   sec_*/min_*/hour_*  BCD ones/tens digits
//   mode         0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC
//   field_blank  blank request {hours, minutes, seconds}
module clock_time_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int HOUR_MOD    = 24
) (
    input  logic       rst,
    input  logic       in_clk,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [3:0] hour_ones,
    output logic [3:0] hour_tens,
    output logic [1:0] mode,
    output logic [2:0] field_blank
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    // Last legal hour value, split into BCD digits.
    localparam logic [3:0] HMAX_T = 4'((HOUR_MOD - 1) / 10);
    localparam logic [3:0] HMAX_O = 4'((HOUR_MOD - 1) % 10);

    state_t r_state;

    logic [3:0] r_s1, r_s10, r_m1, r_m10, r_h1, r_h10;

    logic [SYNC_STAGES-1:0] r_mode_sync;
    logic [SYNC_STAGES-1:0] r_inc_sync;
    logic                   r_mode_prev;
    logic                   r_inc_prev;

    logic       w_mode_p;
    logic       w_inc_p;
    logic [7:0] w_sec_nx;
    logic [7:0] w_min_nx;
    logic [7:0] w_hr_nx;
    logic       w_sec_wrap;
    logic       w_min_wrap;

    // Next value of a 00..59 BCD pair, {tens, ones}.
    function automatic logic [7:0] inc60(input logic [3:0] t,
                                         input logic [3:0] o);
        if (o == 4'd9)
            return (t == 4'd5) ? 8'h00 : {t + 4'd1, 4'd0};
        else
            return {t, o + 4'd1};
    endfunction

    // Next hour value, wrapping at HOUR_MOD-1.
    function automatic logic [7:0] inc_hr(input logic [3:0] t,
                                          input logic [3:0] o);
        if (t == HMAX_T && o == HMAX_O)
            return 8'h00;
        else if (o == 4'd9)
            return {t + 4'd1, 4'd0};
        else
            return {t, o + 4'd1};
    endfunction

    // Button synchronizers and rising-edge detectors.
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            r_mode_sync <= '0;
            r_inc_sync  <= '0;
            r_mode_prev <= 1'b0;
            r_inc_prev  <= 1'b0;
        end else begin
            r_mode_sync <= {r_mode_sync[SYNC_STAGES-2:0], btn_mode};
            r_inc_sync  <= {r_inc_sync[SYNC_STAGES-2:0], btn_inc};
            r_mode_prev <= r_mode_sync[SYNC_STAGES-1];
            r_inc_prev  <= r_inc_sync[SYNC_STAGES-1];
        end
    end

    assign w_mode_p = r_mode_sync[SYNC_STAGES-1] & ~r_mode_prev;
    assign w_inc_p  = r_inc_sync[SYNC_STAGES-1] & ~r_inc_prev;

    assign w_sec_nx   = inc60(r_s10, r_s1);
    assign w_min_nx   = inc60(r_m10, r_m1);
    assign w_hr_nx    = inc_hr(r_h10, r_h1);
    assign w_sec_wrap = (r_s10 == 4'd5) && (r_s1 == 4'd9);
    assign w_min_wrap = (r_m10 == 4'd5) && (r_m1 == 4'd9);

    // Set-mode FSM and time registers. A mode pulse always moves the
    // state and drops any coincident inc; a RUN tick still counts.
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
            r_s1    <= 4'd0;
            r_s10   <= 4'd0;
            r_m1    <= 4'd0;
            r_m10   <= 4'd0;
            r_h1    <= 4'd0;
            r_h10   <= 4'd0;
        end else begin
            if (w_mode_p) begin
                case (r_state)
                    RUN:      r_state <= SET_HOUR;
                    SET_HOUR: r_state <= SET_MIN;
                    SET_MIN:  r_state <= SET_SEC;
                    default:  r_state <= RUN;
                endcase
            end

            if (r_state == RUN) begin
                if (tick) begin
                    {r_s10, r_s1} <= w_sec_nx;
                    if (w_sec_wrap) begin
                        {r_m10, r_m1} <= w_min_nx;
                        if (w_min_wrap)
                            {r_h10, r_h1} <= w_hr_nx;
                    end
                end
            end else if (w_inc_p && !w_mode_p) begin
                case (r_state)
                    SET_HOUR: {r_h10, r_h1} <= w_hr_nx;
                    SET_MIN:  {r_m10, r_m1} <= w_min_nx;
                    default:  {r_s10, r_s1} <= 8'h00;
                endcase
            end
        end
    end

    assign sec_ones  = r_s1;
    assign sec_tens  = r_s10;
    assign min_ones  = r_m1;
    assign min_tens  = r_m10;
    assign hour_ones = r_h1;
    assign hour_tens = r_h10;
    assign mode      = r_state;

`ifdef CLOCK_TIME_CTRL_BLINK_EN
    logic r_blink;

    // Cleared on mode so the newly selected field shows at once.
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst)
            r_blink <= 1'b0;
        else if (w_mode_p)
            r_blink <= 1'b0;
        else if (tick)
            r_blink <= ~r_blink;
    end

    always_comb begin
        field_blank = 3'b000;
        case (r_state)
            SET_HOUR: field_blank = {r_blink, 2'b00};
            SET_MIN:  field_blank = {1'b0, r_blink, 1'b0};
            SET_SEC:  field_blank = {2'b00, r_blink};
            default:  field_blank = 3'b000;
        endcase
    end
`else
    assign field_blank = 3'b000;
`endif

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl: directed bench for clock_time_ctrl.
// Time is compared as packed {hh, mm, ss} BCD.
module tb_clock_time_ctrl;

    localparam int SYNC = 2;

`ifdef CLOCK_TIME_CTRL_BLINK_EN
    localparam logic [2:0] MIN_BLINK = 3'b010;
`else
    localparam logic [2:0] MIN_BLINK = 3'b000;
`endif

    logic       rst = 1'b0;
    logic       in_clk = 1'b0;
    logic       tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic [3:0] hour_ones, hour_tens;
    logic [1:0] mode;
    logic [2:0] field_blank;

    int checks = 0;
    int failures = 0;

    clock_time_ctrl #(.SYNC_STAGES(SYNC), .HOUR_MOD(24)) dut (
        .rst         (rst),
        .in_clk      (in_clk),
        .tick        (tick),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .sec_ones    (sec_ones),
        .sec_tens    (sec_tens),
        .min_ones    (min_ones),
        .min_tens    (min_tens),
        .hour_ones   (hour_ones),
        .hour_tens   (hour_tens),
        .mode        (mode),
        .field_blank (field_blank)
    );

    always #5 in_clk = ~in_clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    function automatic logic [23:0] now_t();
        return {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) do_tick();
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        repeat (SYNC + 1) step();
        btn_mode = 1'b0;
        repeat (SYNC + 1) step();
    endtask

    task automatic press_inc(input int n);
        repeat (n) begin
            btn_inc = 1'b1;
            repeat (SYNC + 1) step();
            btn_inc = 1'b0;
            repeat (SYNC + 1) step();
        end
    endtask

    task automatic test_reset();
        repeat (2) step();
        checks++;
        if (now_t() !== 24'h000000) begin
            failures++;
            $display("FAIL reset_time got=%h exp=000000", now_t());
        end
        checks++;
        if (mode !== 2'd0) begin
            failures++;
            $display("FAIL reset_mode got=%0d exp=0", mode);
        end
        checks++;
        if (field_blank !== 3'b000) begin
            failures++;
            $display("FAIL reset_blank got=%b exp=000", field_blank);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_run();
        ticks(10);
        checks++;
        if (now_t() !== 24'h000010) begin
            failures++;
            $display("FAIL run10 got=%h exp=000010", now_t());
        end
        ticks(51);
        checks++;
        if (now_t() !== 24'h000101 || mode !== 2'd0) begin
            failures++;
            $display("FAIL run61 got=%h mode=%0d exp=000101 mode=0",
                     now_t(), mode);
        end
        press_inc(1);
        checks++;
        if (now_t() !== 24'h000101 || mode !== 2'd0) begin
            failures++;
            $display("FAIL run_inc got=%h mode=%0d exp=000101 mode=0",
                     now_t(), mode);
        end
    endtask

    task automatic test_rollover();
        press_mode();
        press_inc(23);
        checks++;
        if (now_t() !== 24'h230101 || mode !== 2'd1) begin
            failures++;
            $display("FAIL pre_hour got=%h mode=%0d exp=230101 mode=1",
                     now_t(), mode);
        end
        press_mode();
        press_inc(58);
        checks++;
        if (now_t() !== 24'h235901 || mode !== 2'd2) begin
            failures++;
            $display("FAIL pre_min got=%h mode=%0d exp=235901 mode=2",
                     now_t(), mode);
        end
        press_mode();
        press_inc(1);
        press_mode();
        checks++;
        if (now_t() !== 24'h235900 || mode !== 2'd0) begin
            failures++;
            $display("FAIL pre_sec got=%h mode=%0d exp=235900 mode=0",
                     now_t(), mode);
        end
        ticks(59);
        checks++;
        if (now_t() !== 24'h235959) begin
            failures++;
            $display("FAIL roll_a got=%h exp=235959", now_t());
        end
        do_tick();
        checks++;
        if (now_t() !== 24'h000000) begin
            failures++;
            $display("FAIL roll_b got=%h exp=000000", now_t());
        end
    endtask

    task automatic test_set_hour();
        logic [7:0] eh [5];
        eh[0] = 8'h23; eh[1] = 8'h00; eh[2] = 8'h01;
        eh[3] = 8'h02; eh[4] = 8'h03;
        ticks(5);
        btn_mode = 1'b1;
        repeat (SYNC) step();
        checks++;
        if (mode !== 2'd0) begin
            failures++;
            $display("FAIL mode_early got=%0d exp=0", mode);
        end
        step();
        checks++;
        if (mode !== 2'd1) begin
            failures++;
            $display("FAIL mode_latency got=%0d exp=1", mode);
        end
        repeat (5) step();
        checks++;
        if (mode !== 2'd1) begin
            failures++;
            $display("FAIL mode_held got=%0d exp=1", mode);
        end
        btn_mode = 1'b0;
        repeat (SYNC + 1) step();
        press_inc(22);
        checks++;
        if (now_t() !== 24'h220005) begin
            failures++;
            $display("FAIL hour22 got=%h exp=220005", now_t());
        end
        for (int i = 0; i < 5; i++) begin
            press_inc(1);
            do_tick();
            checks++;
            if (now_t() !== {eh[i], 16'h0005}) begin
                failures++;
                $display("FAIL hour_inc%0d got=%h exp=%h",
                         i, now_t(), {eh[i], 16'h0005});
            end
        end
    endtask

    task automatic test_min_sec();
        press_mode();
        press_inc(59);
        checks++;
        if (now_t() !== 24'h035905 || mode !== 2'd2) begin
            failures++;
            $display("FAIL min59 got=%h mode=%0d exp=035905 mode=2",
                     now_t(), mode);
        end
        press_inc(1);
        checks++;
        if (now_t() !== 24'h030005) begin
            failures++;
            $display("FAIL min_wrap got=%h exp=030005", now_t());
        end
        press_mode();
        press_mode();
        ticks(32);
        checks++;
        if (now_t() !== 24'h030037 || mode !== 2'd0) begin
            failures++;
            $display("FAIL sec37 got=%h mode=%0d exp=030037 mode=0",
                     now_t(), mode);
        end
        press_mode();
        press_mode();
        press_mode();
        ticks(3);
        press_inc(1);
        checks++;
        if (now_t() !== 24'h030000 || mode !== 2'd3) begin
            failures++;
            $display("FAIL sec_clr got=%h mode=%0d exp=030000 mode=3",
                     now_t(), mode);
        end
        press_mode();
        do_tick();
        checks++;
        if (now_t() !== 24'h030001 || mode !== 2'd0) begin
            failures++;
            $display("FAIL resume got=%h mode=%0d exp=030001 mode=0",
                     now_t(), mode);
        end
    endtask

    task automatic test_simultaneous();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        press_mode();
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        repeat (SYNC + 1) step();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (SYNC + 1) step();
        checks++;
        if (now_t() !== 24'h000000 || mode !== 2'd2) begin
            failures++;
            $display("FAIL mode_inc got=%h mode=%0d exp=000000 mode=2",
                     now_t(), mode);
        end
        press_mode();
        press_mode();
        ticks(9);
        btn_mode = 1'b1;
        repeat (SYNC) step();
        do_tick();
        checks++;
        if (now_t() !== 24'h000010 || mode !== 2'd1) begin
            failures++;
            $display("FAIL mode_tick got=%h mode=%0d exp=000010 mode=1",
                     now_t(), mode);
        end
        btn_mode = 1'b0;
        repeat (SYNC + 1) step();
        btn_inc = 1'b1;
        repeat (SYNC) step();
        do_tick();
        checks++;
        if (now_t() !== 24'h010010 || mode !== 2'd1) begin
            failures++;
            $display("FAIL inc_tick got=%h mode=%0d exp=010010 mode=1",
                     now_t(), mode);
        end
        btn_inc = 1'b0;
        repeat (SYNC + 1) step();
    endtask

    task automatic test_reset_mid_set();
        press_inc(11);
        press_mode();
        press_inc(34);
        press_mode();
        press_inc(1);
        press_mode();
        ticks(56);
        press_mode();
        press_mode();
        checks++;
        if (now_t() !== 24'h123456 || mode !== 2'd2 ||
            field_blank !== 3'b000) begin
            failures++;
            $display("FAIL setmin got=%h mode=%0d blank=%b exp=123456 2 000",
                     now_t(), mode, field_blank);
        end
        do_tick();
        checks++;
        if (field_blank !== MIN_BLINK || now_t() !== 24'h123456) begin
            failures++;
            $display("FAIL blink_a got=%b t=%h exp=%b t=123456",
                     field_blank, now_t(), MIN_BLINK);
        end
        do_tick();
        checks++;
        if (field_blank !== 3'b000) begin
            failures++;
            $display("FAIL blink_b got=%b exp=000", field_blank);
        end
        do_tick();
        checks++;
        if (field_blank !== MIN_BLINK) begin
            failures++;
            $display("FAIL blink_c got=%b exp=%b", field_blank, MIN_BLINK);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (now_t() !== 24'h000000 || mode !== 2'd0 ||
            field_blank !== 3'b000) begin
            failures++;
            $display("FAIL async_rst got=%h mode=%0d blank=%b exp=000000 0 000",
                     now_t(), mode, field_blank);
        end
        #10;
        rst = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_run();
        test_rollover();
        test_set_hour();
        test_min_sec();
        test_simultaneous();
        test_reset_mid_set();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
